twos_comp_seq: RTL
==================

# twos_comp_seq

Parametrised, multi-cycle two's-complement unit that negates, takes the absolute value of, or passes through a WIDTH-bit signed operand. It processes CHUNK bits per cycle and carries between chunks in a register. Valid/ready handshakes on both sides let it sit between streaming arithmetic stages. It replaces the fixed 4-bit combinational negator wherever wide operands or area-limited carry chains are needed.

## Interface
- WIDTH, 16: operand width in bits; must be at least 2.
- CHUNK, 4: bits processed per cycle. WIDTH % CHUNK must be 0. N = WIDTH/CHUNK.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset; one clock, reset is asynchronous and active-low.
- in_valid  in  1  operand and mode are valid.
- in_ready  out  1  unit can accept an operand (combinational from state and out_ready).
- x  in  WIDTH  signed operand.
- mode  in  2  00 PASS, 01 NEG, 10 ABS, 11 reserved (behaves as PASS).
- out_valid  out  1  y and ovf are valid.
- out_ready  in  1  downstream accepts the result.
- y  out  WIDTH  result.
- ovf  out  1  set when NEG/ABS is applied to the most negative value.

## Operation
- FSM states:
  - IDLE -> BUSY on accept (in_valid & in_ready).
  - BUSY -> DONE after N chunk cycles.
  - DONE -> IDLE on out_ready & !in_valid.
  - DONE -> BUSY on out_ready & in_valid (back-to-back accept).
- in_ready = (state==IDLE) | (state==DONE & out_ready).
- On accept, register the following:
  - x_r = x
  - inv = (mode==NEG) | (mode==ABS & x[WIDTH-1])
  - carry = inv
  - idx = 0
  - ovf_r = inv & (x == {1'b1, {WIDTH-1{1'b0}}})
- BUSY cycle k (LSB chunk first):
  - {c, s} = (x_r[k*CHUNK +: CHUNK] ^ {CHUNK{inv}}) + carry
  - y[k*CHUNK +: CHUNK] <= s
  - carry <= c
  - idx <= idx+1
- Final carry-out is discarded. Arithmetic is modulo 2^WIDTH:
  - NEG of 0 gives 0 with ovf=0.
  - NEG or ABS of MIN gives MIN with ovf=1.
- PASS produces y = x with ovf=0.
- Intermediate y chunks may change during BUSY. Downstream qualifies y only with out_valid.
- In DONE, y, ovf and out_valid are held stable while out_ready is low. in_valid is ignored (in_ready=0).

## Timing
- Reset values:
  - state = IDLE, out_valid = 0, y = 0, ovf = 0, carry = 0, idx = 0.
  - in_ready reads 1 once state is IDLE.
- Reset assertion mid-BUSY or mid-DONE aborts the operation immediately. The partial result is discarded and no out_valid pulse occurs.
- Latency: out_valid rises N clock edges after the accept edge. For example, with WIDTH=16 and CHUNK=4, accept on edge 0 gives out_valid high after edge 4.
- Throughput: with out_ready held high and in_valid continuous, one result per N+1 cycles. The DONE cycle overlaps the next accept.
- A result is consumed on an edge with out_valid & out_ready. out_valid drops on that edge unless the FSM returns to DONE, which is impossible when N≥1.
- CHUNK==WIDTH: N=1, single BUSY cycle.
- CHUNK==1: bit-serial, N=WIDTH.

## Structure
- Package twos_comp_pkg holds:
  - mode constants MODE_PASS=2'b00, MODE_NEG=2'b01, MODE_ABS=2'b10, MODE_RSVD=2'b11
  - FSM state encoding ST_IDLE, ST_BUSY, ST_DONE
  - the mode width constant (2)
- One sub-module, twos_comp_chunk: combinational CHUNK-bit slice.
  - Inputs: CHUNK-bit data, inv, carry_in.
  - Outputs: CHUNK-bit sum and carry_out.
  - Instantiated once and muxed by idx.
- Elaboration-time check fails when WIDTH % CHUNK != 0 or WIDTH < 2.

## Test plan
- WIDTH=16, CHUNK=4, NEG x=0x0005 -> y=0xFFFB, ovf=0; out_valid exactly 4 edges after accept.
- ABS x=0xFFFB -> y=0x0005, ovf=0. ABS x=0x0007 -> y=0x0007. PASS and reserved mode with x=0xA5C3 -> y=0xA5C3.
- NEG x=0x8000 -> y=0x8000, ovf=1. ABS x=0x8000 -> y=0x8000, ovf=1. NEG x=0x0000 -> y=0x0000, ovf=0.
- Backpressure:
  - Hold out_ready low 3 cycles in DONE -> y, ovf and out_valid stable, in_ready=0.
  - Raise out_ready with in_valid=1 (NEG 0x0001) -> accepted on the same edge; y=0xFFFF 4 edges later.
- Reset: assert rst_n low after the 2nd BUSY edge -> out_valid=0, y=0, ovf=0 immediately. After release, NEG 0x1234 -> 0xEDCC.
- Parameter sweep over (16,1), (16,16), (8,2) and (32,8):
  - 200 random operands per configuration with random modes and random out_ready.
  - Check against a reference model computing -x / |x| mod 2^WIDTH.
  - Check latency N.

Source files
------------

// File: rtl/twos_comp_pkg.sv
// Shared definitions for the sequential two's-complement unit.
//   - mode encodings (PASS, NEG, ABS, reserved)
//   - FSM state encoding
//   - mode field width
package twos_comp_pkg;

  localparam int unsigned MODE_W = 2;

  localparam logic [MODE_W-1:0] MODE_PASS = 2'b00;
  localparam logic [MODE_W-1:0] MODE_NEG  = 2'b01;
  localparam logic [MODE_W-1:0] MODE_ABS  = 2'b10;
  localparam logic [MODE_W-1:0] MODE_RSVD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/twos_comp_chunk.sv
// Combinational CHUNK-bit slice of a conditional two's-complement.
//   data_in   : CHUNK-bit operand slice
//   inv       : invert the slice before adding the carry
//   carry_in  : carry from the previous (less significant) slice
//   sum       : CHUNK-bit result slice
//   carry_out : carry into the next slice
module twos_comp_chunk #(
  parameter int unsigned CHUNK = 4
) (
  input  logic [CHUNK-1:0] data_in,
  input  logic             inv,
  input  logic             carry_in,
  output logic [CHUNK-1:0] sum,
  output logic             carry_out
);

  assign {carry_out, sum} = {1'b0, data_in ^ {CHUNK{inv}}} + {{CHUNK{1'b0}}, carry_in};

endmodule

// File: rtl/twos_comp_seq.sv
// Multi-cycle two's-complement unit: PASS, NEG or ABS of a WIDTH-bit signed
// operand, CHUNK bits per cycle, LSB chunk first, with valid/ready on both sides.
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid / in_ready  : operand handshake (in_ready is combinational)
//   x, mode              : operand and operation (11 behaves as PASS)
//   out_valid / out_ready: result handshake
//   y, ovf               : result, overflow (NEG/ABS of the most negative value)
module twos_comp_seq
  import twos_comp_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  x,
  input  logic [MODE_W-1:0] mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  y,
  output logic              ovf
);

  localparam int unsigned N    = (CHUNK == 0) ? 1 : WIDTH / CHUNK;
  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;

  if ((CHUNK < 1) || (WIDTH < 2) || ((WIDTH % CHUNK) != 0)) begin : g_param_err
    $error("twos_comp_seq: WIDTH must be >= 2 and a multiple of CHUNK");
  end

  state_e            state_q;
  logic [WIDTH-1:0]  x_q;
  logic [WIDTH-1:0]  y_q;
  logic              inv_q;
  logic              carry_q;
  logic              ovf_q;
  logic              out_valid_q;
  logic [IdxW-1:0]   idx_q;

  logic              accept;
  logic              inv_d;
  logic              last_chunk;
  logic [CHUNK-1:0]  chunk_in;
  logic [CHUNK-1:0]  chunk_sum;
  logic              chunk_cout;

  assign in_ready   = (state_q == ST_IDLE) | ((state_q == ST_DONE) & out_ready);
  assign accept     = in_valid & in_ready;
  assign inv_d      = (mode == MODE_NEG) | ((mode == MODE_ABS) & x[WIDTH-1]);
  assign last_chunk = (idx_q == IdxW'(N - 1));

  always_comb begin
    chunk_in = '0;
    for (int k = 0; k < N; k++) begin
      if (idx_q == IdxW'(k)) chunk_in = x_q[k*CHUNK +: CHUNK];
    end
  end

  twos_comp_chunk #(
    .CHUNK(CHUNK)
  ) u_chunk (
    .data_in  (chunk_in),
    .inv      (inv_q),
    .carry_in (carry_q),
    .sum      (chunk_sum),
    .carry_out(chunk_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      x_q         <= '0;
      y_q         <= '0;
      inv_q       <= 1'b0;
      carry_q     <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      idx_q       <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: ;
        ST_BUSY: begin
          for (int k = 0; k < N; k++) begin
            if (idx_q == IdxW'(k)) y_q[k*CHUNK +: CHUNK] <= chunk_sum;
          end
          // Carry out of the top chunk is simply left behind: arithmetic is mod 2^WIDTH.
          carry_q <= chunk_cout;
          idx_q   <= idx_q + IdxW'(1);
          if (last_chunk) begin
            state_q     <= ST_DONE;
            out_valid_q <= 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase

      // Accept is only possible from IDLE or from DONE with out_ready, so it
      // overrides the DONE->IDLE transition above for back-to-back operation.
      if (accept) begin
        state_q <= ST_BUSY;
        x_q     <= x;
        inv_q   <= inv_d;
        carry_q <= inv_d;
        idx_q   <= '0;
        ovf_q   <= inv_d & (x == {1'b1, {(WIDTH-1){1'b0}}});
      end
    end
  end

  assign out_valid = out_valid_q;
  assign y         = y_q;
  assign ovf       = ovf_q;

endmodule
